// File: rtl/slc3_input_cond_if.sv
// Board-input bundle between the raw pins and the SLC-3 control logic.
// master = pin/stimulus side, slave = conditioning stage.
interface slc3_input_cond_if #(
    parameter int SW_WIDTH = 10
);
    logic                Run_n_raw;
    logic                Continue_n_raw;
    logic [SW_WIDTH-1:0] SW_raw;
    logic                Run_pulse;
    logic                Continue_pulse;
    logic                Run_held;
    logic                Continue_held;
    logic [SW_WIDTH-1:0] SW_sync;
    // Button FSM states, exposed for observation only.
    logic [1:0]          run_state_dbg;
    logic [1:0]          cont_state_dbg;

    modport master (
        output Run_n_raw, Continue_n_raw, SW_raw,
        input  Run_pulse, Continue_pulse, Run_held, Continue_held, SW_sync,
        input  run_state_dbg, cont_state_dbg
    );

    modport slave (
        input  Run_n_raw, Continue_n_raw, SW_raw,
        output Run_pulse, Continue_pulse, Run_held, Continue_held, SW_sync,
        output run_state_dbg, cont_state_dbg
    );
endinterface

// File: rtl/slc3_input_cond.sv
// Synchronizes and debounces the Run/Continue keys and slide switches for the SLC-3.
// Define INPUT_COND_AUTOREPEAT_EN to make Continue_pulse auto-repeat while held.
module slc3_input_cond #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SW_WIDTH        = 10,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input logic               Clk,
    input logic               Reset_n,
    slc3_input_cond_if.slave  bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Index 0 = Run, index 1 = Continue; sync flops carry the active-low pin level.
    logic [1:0]          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [1:0]          pressed;
    btn_state_e          state_q [2];
    btn_state_e          state_d [2];
    logic [CW-1:0]       cnt_q [2];
    logic [CW-1:0]       cnt_d [2];
    logic [1:0]          pulse_q, pulse_d;
    logic                rpt_fire;

    logic [SW_WIDTH-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d, sw_out_q, sw_out_d;
    logic [CW-1:0]       sw_cnt_q, sw_cnt_d;

    assign pressed = ~btn_s2_q;

    always_comb begin
        btn_s1_d  = {bus.Continue_n_raw, bus.Run_n_raw};
        btn_s2_d  = btn_s1_q;
        sw_s1_d   = bus.SW_raw;
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            case (state_q[i])
                RELEASED: begin
                    if (pressed[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A re-press here is contact bounce: back to PRESSED silently.
                    if (pressed[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        pulse_d[1] = pulse_d[1] | rpt_fire;
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int            RW      = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q, rpt_d;

    // Runs only while Continue sits in PRESSED; any exit clears it.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q[1] == PRESSED && pressed[1]) begin
            if (rpt_q == RPT_MAX) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Load only after the whole vector has matched its previous sample long enough.
    always_comb begin
        sw_cnt_d = sw_cnt_q;
        sw_out_d = sw_out_q;
        if (sw_s2_q != sw_prev_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CNT_MAX) begin
            sw_out_d = sw_s2_q;
        end else begin
            sw_cnt_d = sw_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_s1_q   <= 2'b11;
            btn_s2_q   <= 2'b11;
            state_q[0] <= RELEASED;
            state_q[1] <= RELEASED;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            pulse_q    <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sw_prev_q  <= '0;
            sw_out_q   <= '0;
            sw_cnt_q   <= '0;
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            pulse_q    <= pulse_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            sw_prev_q  <= sw_prev_d;
            sw_out_q   <= sw_out_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign bus.Run_pulse      = pulse_q[0];
    assign bus.Continue_pulse = pulse_q[1];
    assign bus.Run_held       = (state_q[0] == PRESSED) || (state_q[0] == RELEASE_WAIT);
    assign bus.Continue_held  = (state_q[1] == PRESSED) || (state_q[1] == RELEASE_WAIT);
    assign bus.SW_sync        = sw_out_q;
    assign bus.run_state_dbg  = state_q[0];
    assign bus.cont_state_dbg = state_q[1];
endmodule

// File: tb/tb_slc3_input_cond.sv
// Bench for slc3_input_cond with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Edge numbers count from the first rising edge that samples a new raw level.
module tb_slc3_input_cond;
    localparam int SWW = 10;
    localparam int W   = 4 + SWW;
`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic Clk;
    logic Reset_n;

    slc3_input_cond_if #(.SW_WIDTH(SWW)) bus ();

    slc3_input_cond #(
        .DEBOUNCE_CYCLES(4),
        .SW_WIDTH       (SWW),
        .REPEAT_CYCLES  (8)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [127:0]  name;
        int            e;
        logic          rn;
        logic          cn;
        logic [SWW-1:0] sw;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] out_word();
        return {bus.Run_pulse, bus.Continue_pulse, bus.Run_held, bus.Continue_held, bus.SW_sync};
    endfunction

    function automatic logic [W-1:0] mk(input logic rp, input logic cp, input logic rh,
                                        input logic ch, input logic [SWW-1:0] sws);
        return {rp, cp, rh, ch, sws};
    endfunction

    task automatic check(input logic [127:0] nm, input int e, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %0s edge %0d: got %h expected %h", nm, e, act, exp);
        end
    endtask

    task automatic compare_head(input logic [127:0] nm, input int e);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %0s edge %0d: scoreboard empty", nm, e);
        end else begin
            exp = exp_q.pop_front();
            check(nm, e, 32'(out_word()), 32'(exp));
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [127:0] nm, input int e, input logic rn, input logic cn,
                        input logic [SWW-1:0] sw, input logic [W-1:0] exp);
        @(negedge Clk);
        bus.Run_n_raw      = rn;
        bus.Continue_n_raw = cn;
        bus.SW_raw         = sw;
        exp_q.push_back(exp);
        @(posedge Clk);
        #1;
        compare_head(nm, e);
    endtask

    task automatic add_vec(input logic [127:0] nm, input int e, input logic rn, input logic cn,
                           input logic [SWW-1:0] sw, input logic [W-1:0] exp);
        vec_t v;
        v.name = nm; v.e = e; v.rn = rn; v.cn = cn; v.sw = sw; v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SWW-1:0] sw_v;
        Reset_n            = 1'b0;
        bus.Run_n_raw      = 1'b1;
        bus.Continue_n_raw = 1'b1;
        bus.SW_raw         = '0;

        // Table: single Run press/release, and a short Continue glitch.
        for (int e = 1; e <= 10; e++)
            add_vec("t1_run_press", e, 1'b0, 1'b1, '0, mk(e == 7, 1'b0, e >= 7, 1'b0, '0));
        for (int e = 1; e <= 8; e++)
            add_vec("t1_run_release", e, 1'b1, 1'b1, '0, mk(1'b0, 1'b0, e < 7, 1'b0, '0));
        for (int e = 1; e <= 8; e++)
            add_vec("t2_cont_glitch", e, 1'b1, (e <= 3) ? 1'b0 : 1'b1, '0, mk(1'b0, 1'b0, 1'b0, 1'b0, '0));

        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", 0, 32'(out_word()), 32'd0);
        check("reset_run_state", 0, 32'(bus.run_state_dbg), 32'd0);
        check("reset_cont_state", 0, 32'(bus.cont_state_dbg), 32'd0);
        Reset_n = 1'b1;

        for (int e = 1; e <= 6; e++)
            step("idle", e, 1'b1, 1'b1, '0, '0);

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].e, vecs[i].rn, vecs[i].cn, vecs[i].sw, vecs[i].exp);
        check("t2_cont_state_released", 0, 32'(bus.cont_state_dbg), 32'd0);

        // Run press, then bounce on release: high 2, low 2, high steady.
        for (int e = 1; e <= 10; e++)
            step("t3_run_press", e, 1'b0, 1'b1, '0, mk(e == 7, 1'b0, e >= 7, 1'b0, '0));
        for (int e = 1; e <= 12; e++)
            step("t3_run_bounce", e, (e == 3 || e == 4) ? 1'b0 : 1'b1, 1'b1, '0,
                 mk(1'b0, 1'b0, e < 11, 1'b0, '0));

        // Switches: settle 0x00B, chatter bit 6 into 0x05B, then 0x077.
        for (int e = 1; e <= 8; e++)
            step("t4_sw_00b", e, 1'b1, 1'b1, 10'h00B, mk(1'b0, 1'b0, 1'b0, 1'b0, (e >= 7) ? 10'h00B : 10'h000));
        for (int e = 1; e <= 11; e++) begin
            sw_v = (e == 2) ? 10'h01B : 10'h05B;
            step("t4_sw_chatter", e, 1'b1, 1'b1, sw_v,
                 mk(1'b0, 1'b0, 1'b0, 1'b0, (e >= 9) ? 10'h05B : 10'h00B));
        end
        for (int e = 1; e <= 8; e++)
            step("t4_sw_077", e, 1'b1, 1'b1, 10'h077, mk(1'b0, 1'b0, 1'b0, 1'b0, (e >= 7) ? 10'h077 : 10'h05B));

        // Both keys together, release, then reset in the middle of PRESS_WAIT.
        for (int e = 1; e <= 8; e++)
            step("t5_both_press", e, 1'b0, 1'b0, 10'h077, mk(e == 7, e == 7, e >= 7, e >= 7, 10'h077));
        for (int e = 1; e <= 8; e++)
            step("t5_both_release", e, 1'b1, 1'b1, 10'h077, mk(1'b0, 1'b0, e < 7, e < 7, 10'h077));
        for (int e = 1; e <= 4; e++)
            step("t5_press_wait", e, 1'b0, 1'b0, 10'h077, mk(1'b0, 1'b0, 1'b0, 1'b0, 10'h077));
        check("t5_pre_reset_state", 4, 32'(bus.run_state_dbg), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("t5_reset_outputs", 0, 32'(out_word()), 32'd0);
        check("t5_reset_run_state", 0, 32'(bus.run_state_dbg), 32'd0);
        check("t5_reset_cont_state", 0, 32'(bus.cont_state_dbg), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int e = 1; e <= 8; e++)
            step("t5_after_reset", e, 1'b0, 1'b0, 10'h077,
                 mk(e == 7, e == 7, e >= 7, e >= 7, (e >= 7) ? 10'h077 : 10'h000));
        for (int e = 1; e <= 8; e++)
            step("t5_release2", e, 1'b1, 1'b1, 10'h077, mk(1'b0, 1'b0, e < 7, e < 7, 10'h077));

        // Continue held 30 cycles: repeats only when auto-repeat is built in.
        for (int e = 1; e <= 40; e++)
            step("t6_cont_hold", e, 1'b1, (e <= 30) ? 1'b0 : 1'b1, 10'h077,
                 mk(1'b0, (e == 7) || (AR && (e == 15 || e == 23 || e == 31)), 1'b0,
                    (e >= 7) && (e < 37), 10'h077));

        // ---------------- report ----------------
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
